stream_parity_unit: RTL
=======================

// Module: stream_parity_unit
// PURPOSE
//  Sequential successor to the 8-bit combinational even-parity generator.
//  Accumulates parity over a packet of WIDTH-bit words on a valid/ready stream.
//  Returns one parity result per packet on a second handshake, in even or odd mode.
//  Checks a sender-supplied expected parity bit and flags length overruns.
//  Sits between a framed data source and the link/CRC framing logic.
// PARAMETERS
//  WIDTH      8   data word width, >=1
//  ODD        0   0: even parity (bit makes total 1s even), 1: odd parity
//  MAX_WORDS  16  max beats per packet, >=1; LEN_W = $clog2(MAX_WORDS+1)
//  CNT_W      8   error counter width (used only with PARITY_ERR_CNT_EN)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  s_valid    in   1      input beat valid
//  s_ready    out  1      input beat accepted when s_valid & s_ready
//  s_data     in   WIDTH  input word
//  s_last     in   1      final beat of packet
//  s_par_exp  in   1      expected parity; sampled only on the closing beat
//  m_valid    out  1      packet result valid
//  m_ready    in   1      result consumed when m_valid & m_ready
//  m_parity   out  1      computed parity bit for packet
//  m_err      out  2      [0] parity mismatch, [1] length overrun
//  m_len      out  LEN_W  beats in packet, 1..MAX_WORDS
//  busy       out  1      high in ACCUM or HOLD
//  err_cnt    out  CNT_W  packets with nonzero m_err (PARITY_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset: state IDLE; acc=0, count=0, m_valid=0, m_parity=0, m_err=0, m_len=0,
//   busy=0, err_cnt=0. s_ready=0 while rst high. Reset mid-packet discards it.
//  s_ready = ~rst & (state != HOLD); registered outputs held stable in HOLD.
//  FSM:
//   IDLE : accepted beat -> acc=^s_data, count=1; closing beat -> HOLD, else ACCUM
//   ACCUM: accepted beat -> acc^=^s_data, count+=1; closing beat -> HOLD
//   HOLD : m_valid=1; m_ready -> IDLE next cycle (no beat accepted in HOLD)
//  Closing beat: s_last=1, or the beat making count==MAX_WORDS (forced close).
//  On closing beat, registered next cycle (latency 1 from last accept):
//   m_parity = acc_final ^ ODD; m_len = count_final
//   m_err[0] = (s_par_exp != m_parity)
//   m_err[1] = forced close with s_last=0
//  After forced close, further beats start a new packet (no resync/discard).
//  MAX_WORDS=1: every beat closes; s_last=0 sets m_err[1].
//  Throughput: one packet per (beats + 1) cycles at best (HOLD costs >=1 cycle).
//  Idle cycles (s_valid=0) inside a packet do not change acc/count.
//  m_valid falls the cycle after the m_valid & m_ready transfer.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined: err_cnt present; +1 on each result transfer with
//   |m_err, saturates at all-ones, cleared only by rst.
//  Not defined: err_cnt port and counter logic absent; all else identical.
// TESTING
//  1 ODD=0, one beat 8'b00000011, s_last=1, exp=0 -> m_parity=0, m_len=1, m_err=00
//  2 ODD=0, beats 8'hAA,8'hDA,8'hFF (last on 3rd), exp=0 -> parity=1, len=3, err=01
//  3 ODD=1, same packet, exp=0 -> m_parity=0, m_err=00
//  4 m_ready low 5 cycles in HOLD -> m_valid/outputs stable, s_ready=0, no beat lost
//  5 MAX_WORDS=4, 6 beats 8'h01, last on 6th -> result len=4 err[1]=1, then len=2
//  6 rst pulse after 2 of 3 beats; new 1-beat packet 8'hFF exp=0 -> parity=0,
//    len=1, err=00; with macro, err_cnt saturates at 255 after 300 errored packets

Source files
------------

// File: rtl/stream_parity_unit.sv
// stream_parity_unit: accumulates parity over a packet of WIDTH-bit words on a
// valid/ready input stream and returns one result per packet on an output handshake.
// Compile-time option: define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module stream_parity_unit #(
  parameter int WIDTH     = 8,
  parameter int ODD       = 0,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 8,
  localparam int LEN_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             s_par_exp,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_parity,
  output logic [1:0]       m_err,
  output logic [LEN_W-1:0] m_len,
  output logic             busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic             ODD_BIT = (ODD != 0);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           state_q;
  logic             acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic             m_valid_q;
  logic             m_parity_q;
  logic [1:0]       m_err_q;
  logic [LEN_W-1:0] m_len_q;

  logic             accept;
  logic             acc_d;
  logic [LEN_W-1:0] cnt_d;
  logic             close_d;
  logic             forced_d;
  logic             parity_d;

  // No beat is taken while a result is waiting, or while reset is asserted.
  assign s_ready = ~rst & (state_q != HOLD);
  assign accept  = s_valid & s_ready;

  // Running parity/count including the current beat; a packet starts fresh in IDLE.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    close_d  = 1'b0;
    forced_d = 1'b0;
    parity_d = 1'b0;
    if (state_q == IDLE) begin
      acc_d = ^s_data;
      cnt_d = LEN_W'(1);
    end else begin
      acc_d = acc_q ^ (^s_data);
      cnt_d = cnt_q + LEN_W'(1);
    end
    forced_d = (cnt_d == MAX_LEN) & ~s_last;
    close_d  = s_last | (cnt_d == MAX_LEN);
    parity_d = acc_d ^ ODD_BIT;
  end

  // Packet FSM with registered result outputs, held stable while in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_parity_q <= 1'b0;
      m_err_q    <= 2'b00;
      m_len_q    <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (close_d) begin
              state_q    <= HOLD;
              m_valid_q  <= 1'b1;
              m_parity_q <= parity_d;
              m_len_q    <= cnt_d;
              m_err_q    <= {forced_d, (s_par_exp != parity_d)};
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid  = m_valid_q;
  assign m_parity = m_parity_q;
  assign m_err    = m_err_q;
  assign m_len    = m_len_q;
  assign busy     = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Count transferred results carrying any error flag, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (m_valid_q & m_ready & (|m_err_q) & ~(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
